// File: rtl/spi_jtag_pkg.sv
// Shared definitions for the JTAG-to-SPI framing controller: FSM states,
// header geometry and the default magic value that marks a valid header.
package spi_jtag_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    XFER,
    DONE,
    IGNORE
  } state_t;

  localparam int HDR_W     = 16;
  localparam int HDR_CNT_W = 4;

  localparam logic [1:0] MAGIC_DEFAULT = 2'b01;

  localparam int LEN_LSB   = 0;
  localparam int KEEP_BIT  = 13;
  localparam int MAGIC_MSB = 15;
  localparam int MAGIC_LSB = 14;

  function automatic logic [1:0] hdrMagic(input logic [HDR_W-1:0] hdr);
    return hdr[MAGIC_MSB:MAGIC_LSB];
  endfunction

  function automatic logic hdrKeep(input logic [HDR_W-1:0] hdr);
    return hdr[KEEP_BIT];
  endfunction

endpackage

// File: rtl/spi_jtag_rd_align.sv
// Extra register stages on the flash DQ1 return path so the read data can
// be lined up with the host's DR bit numbering. DEPTH of zero is a wire.
module spi_jtag_rd_align #(
  parameter int DEPTH = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_din,
  output logic o_dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign o_dout = i_din;
    end else begin : g_pipe
      logic [DEPTH-1:0] r_pipe;

      // Shift the flash output through DEPTH stages, cleared on reset
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_pipe <= '0;
        end else begin
          r_pipe[0] <= i_din;
          for (int i = 1; i < DEPTH; i++) begin
            r_pipe[i] <= r_pipe[i-1];
          end
        end
      end

      assign o_dout = r_pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/spi_jtag_frame_ctrl.sv
// Header-described SPI framing behind a USER-chain JTAG primitive.
// The host shifts a 16-bit header (LSB first) followed by the SPI bits; the
// block drives CS, the SCK gate enable and DQ0 for exactly the announced
// bit count and returns DQ1 on TDO. A keep flag in the header lets the host
// hold CS low across DR scans to chain flash commands.
module spi_jtag_frame_ctrl
  import spi_jtag_pkg::*;
#(
  parameter int         LEN_W  = 13,
  parameter int         RD_DLY = 1,
  parameter logic [1:0] MAGIC  = MAGIC_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sel,
  input  logic i_capture,
  input  logic i_shift,
  input  logic i_update,
  input  logic i_tdi,
  output logic o_tdo,
  input  logic i_sdo_dq1,
  output logic o_sdi_dq0,
  output logic o_csn,
  output logic o_sck_en,
  output logic o_busy
);

  localparam logic [HDR_CNT_W-1:0] HDR_LAST = HDR_CNT_W'(HDR_W - 1);
  localparam logic [LEN_W-1:0]     LEN_ONE  = LEN_W'(1);

  state_t               r_state;
  state_t               w_stateNext;

  logic [HDR_W-2:0]     r_hdr;
  logic [HDR_W-2:0]     w_hdrNext;
  logic [HDR_W-1:0]     w_hdrFull;
  logic [HDR_CNT_W-1:0] r_hdrCnt;
  logic [HDR_CNT_W-1:0] w_hdrCntNext;
  logic [LEN_W-1:0]     r_bitCnt;
  logic [LEN_W-1:0]     w_bitCntNext;
  logic [LEN_W-1:0]     w_hdrLen;
  logic                 r_keep;
  logic                 w_keepNext;
  logic                 r_csn;
  logic                 w_csnNext;
  logic                 r_sckEn;
  logic                 w_sckEnNext;
  logic                 r_sdiDq0;
  logic                 w_sdiNext;
  logic                 r_tdo;
  logic                 w_tdoNext;

  logic                 w_act;
  logic                 w_frameUpdate;
  logic                 w_frameCapture;
  logic                 w_sdoAligned;

  assign w_act          = i_sel & i_shift;
  assign w_frameUpdate  = i_sel & i_update;
  assign w_frameCapture = i_sel & i_capture;

  // The header as it will look once the current tdi bit is shifted in; only
  // meaningful on the sixteenth header bit, where it is evaluated.
  assign w_hdrFull = {i_tdi, r_hdr};
  assign w_hdrLen  = w_hdrFull[LEN_LSB +: LEN_W];

  spi_jtag_rd_align #(
    .DEPTH (RD_DLY)
  ) u_rdAlign (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_din  (i_sdo_dq1),
    .o_dout (w_sdoAligned)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and next-datapath logic; update beats capture beats shifting
  always_comb begin
    w_stateNext  = r_state;
    w_hdrNext    = r_hdr;
    w_hdrCntNext = r_hdrCnt;
    w_bitCntNext = r_bitCnt;
    w_keepNext   = r_keep;
    w_csnNext    = r_csn;
    w_sckEnNext  = 1'b0;
    w_sdiNext    = r_sdiDq0;

    if (w_frameUpdate) begin
      w_stateNext  = IDLE;
      w_bitCntNext = '0;
      if (r_state == XFER) begin
        w_csnNext  = 1'b1;
        w_keepNext = 1'b0;
      end else begin
        w_csnNext  = ~r_keep;
      end
    end else if (w_frameCapture) begin
      w_stateNext  = HDR;
      w_hdrCntNext = '0;
    end else begin
      case (r_state)
        HDR: begin
          if (w_act) begin
            w_hdrNext    = w_hdrFull[HDR_W-1:1];
            w_hdrCntNext = r_hdrCnt + 1'b1;
            if (r_hdrCnt == HDR_LAST) begin
              if (hdrMagic(w_hdrFull) != MAGIC) begin
                w_stateNext = IGNORE;
              end else begin
                w_keepNext = hdrKeep(w_hdrFull);
                if (w_hdrLen == '0) begin
                  w_stateNext = DONE;
                end else begin
                  w_stateNext  = XFER;
                  w_bitCntNext = w_hdrLen;
                end
              end
            end
          end
        end
        XFER: begin
          if (w_act) begin
            w_sdiNext   = i_tdi;
            w_sckEnNext = 1'b1;
            w_csnNext   = 1'b0;
            if (r_bitCnt != '0) begin
              w_bitCntNext = r_bitCnt - 1'b1;
            end
            if (r_bitCnt <= LEN_ONE) begin
              w_stateNext = DONE;
            end
          end
        end
        DONE: begin
          w_csnNext = ~r_keep;
        end
        default: begin
        end
      endcase
    end
  end

  // TDO source: aligned flash data while a transfer is live, else tdi echo
  always_comb begin
    w_tdoNext = i_tdi;
    if ((r_state == XFER) || (r_state == DONE)) begin
      w_tdoNext = w_sdoAligned;
    end
  end

  // Datapath and SPI pin registers; all pins lag tdi by one clock
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hdr    <= '0;
      r_hdrCnt <= '0;
      r_bitCnt <= '0;
      r_keep   <= 1'b0;
      r_csn    <= 1'b1;
      r_sckEn  <= 1'b0;
      r_sdiDq0 <= 1'b0;
      r_tdo    <= 1'b0;
    end else begin
      r_hdr    <= w_hdrNext;
      r_hdrCnt <= w_hdrCntNext;
      r_bitCnt <= w_bitCntNext;
      r_keep   <= w_keepNext;
      r_csn    <= w_csnNext;
      r_sckEn  <= w_sckEnNext;
      r_sdiDq0 <= w_sdiNext;
      r_tdo    <= w_tdoNext;
    end
  end

  assign o_tdo     = r_tdo;
  assign o_sdi_dq0 = r_sdiDq0;
  assign o_csn     = r_csn;
  assign o_sck_en  = r_sckEn;
  assign o_busy    = (r_state == XFER);

endmodule

// File: tb/tb_spi_jtag_frame_ctrl.sv
// Directed bench for spi_jtag_frame_ctrl: reset, read-ID, bad magic,
// chained frames, abort, zero length and a mid-transfer reset.
module tb_spi_jtag_frame_ctrl;

  localparam int RD_DLY = 1;

  logic clk;
  logic rst;
  logic sel;
  logic capture;
  logic shift;
  logic update;
  logic tdi;
  logic sdoDq1;
  logic tdo;
  logic sdiDq0;
  logic csn;
  logic sckEn;
  logic busy;

  int checks      = 0;
  int failures    = 0;
  int sckCount    = 0;
  int csnLowCount = 0;

  logic [31:0] got;
  logic [7:0]  pat;

  spi_jtag_frame_ctrl #(
    .LEN_W  (13),
    .RD_DLY (RD_DLY),
    .MAGIC  (2'b01)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_sel     (sel),
    .i_capture (capture),
    .i_shift   (shift),
    .i_update  (update),
    .i_tdi     (tdi),
    .o_tdo     (tdo),
    .i_sdo_dq1 (sdoDq1),
    .o_sdi_dq0 (sdiDq0),
    .o_csn     (csn),
    .o_sck_en  (sckEn),
    .o_busy    (busy)
  );

  // Free-running shift clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one clock of TAP inputs, then sample just after the rising edge
  task automatic applyStimulus(input logic s, input logic c, input logic sh,
                               input logic u, input logic d, input logic f);
    sel     = s;
    capture = c;
    shift   = sh;
    update  = u;
    tdi     = d;
    sdoDq1  = f;
    @(posedge clk);
    #1;
    if (sckEn === 1'b1) sckCount++;
    if (csn === 1'b0) csnLowCount++;
  endtask

  task automatic shiftBit(input logic d, input logic f);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, d, f);
  endtask

  task automatic doUpdate();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Capture then shift a header LSB first; TDO must echo tdi one clock late
  task automatic sendHeader(input logic [15:0] h);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      shiftBit(h[i], 1'b0);
      checkOutput("hdr_echo", {31'd0, tdo}, {31'd0, h[i]});
    end
  endtask

  // Shift n SPI bits (wire order = vector MSB first) plus 1+RD_DLY pad bits.
  // The flash model presents response bit k in the same clock as MOSI bit k;
  // it comes back on TDO 1+RD_DLY clocks later.
  task automatic xferBits(input int n, input logic [31:0] mosiVec,
                          input logic [31:0] misoVec, output logic [31:0] rx);
    logic dBit;
    logic fBit;
    int   idx;
    rx = '0;
    for (int k = 0; k < n + 1 + RD_DLY; k++) begin
      dBit = 1'b0;
      fBit = 1'b0;
      if (k < n) begin
        dBit = mosiVec[n-1-k];
        fBit = misoVec[n-1-k];
      end
      shiftBit(dBit, fBit);
      if (k < n) begin
        checkOutput("xfer_sdi", {31'd0, sdiDq0}, {31'd0, dBit});
        checkOutput("xfer_csn", {31'd0, csn}, 32'd0);
      end
      idx = k - RD_DLY;
      if ((idx >= 0) && (idx < n)) rx[n-1-idx] = tdo;
    end
  endtask

  initial begin
    rst     = 1'b1;
    sel     = 1'b0;
    capture = 1'b0;
    shift   = 1'b0;
    update  = 1'b0;
    tdi     = 1'b0;
    sdoDq1  = 1'b0;

    $display("[TB] reset with random inputs");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checkOutput("rst_csn", {31'd0, csn}, 32'd1);
      checkOutput("rst_sck_en", {31'd0, sckEn}, 32'd0);
      checkOutput("rst_tdo", {31'd0, tdo}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    end
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_csn", {31'd0, csn}, 32'd1);

    $display("[TB] read ID 0x9F");
    sckCount    = 0;
    csnLowCount = 0;
    sendHeader(16'h4020);
    checkOutput("rdid_busy_start", {31'd0, busy}, 32'd1);
    xferBits(32, 32'h9F00_0000, 32'h00EF_4018, got);
    checkOutput("rdid_resp", {8'd0, got[23:0]}, 32'h00EF_4018);
    checkOutput("rdid_sck_count", sckCount, 32'd32);
    checkOutput("rdid_csn_low_count", csnLowCount, 32'd32);
    checkOutput("rdid_csn_done", {31'd0, csn}, 32'd1);
    checkOutput("rdid_busy_done", {31'd0, busy}, 32'd0);
    doUpdate();
    checkOutput("rdid_csn_update", {31'd0, csn}, 32'd1);

    $display("[TB] bad magic header");
    sckCount    = 0;
    csnLowCount = 0;
    pat         = 8'hB2;
    sendHeader(16'hC008);
    for (int i = 0; i < 8; i++) begin
      shiftBit(pat[i], 1'b1);
      checkOutput("ign_echo", {31'd0, tdo}, {31'd0, pat[i]});
    end
    checkOutput("ign_sck_count", sckCount, 32'd0);
    checkOutput("ign_csn_low_count", csnLowCount, 32'd0);
    checkOutput("ign_busy", {31'd0, busy}, 32'd0);
    doUpdate();
    checkOutput("ign_csn_update", {31'd0, csn}, 32'd1);

    $display("[TB] chained frames with keep");
    sckCount = 0;
    sendHeader(16'h6008);
    xferBits(8, 32'h0000_0006, 32'h0000_0000, got);
    checkOutput("chainA_csn_done", {31'd0, csn}, 32'd0);
    doUpdate();
    checkOutput("chainA_csn_update", {31'd0, csn}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("chainB_csn_capture", {31'd0, csn}, 32'd0);
    sendHeader(16'h4010);
    checkOutput("chainB_csn_hdr", {31'd0, csn}, 32'd0);
    xferBits(16, 32'h0000_0500, 32'h0000_0003, got);
    checkOutput("chainB_status", {24'd0, got[7:0]}, 32'h0000_0003);
    checkOutput("chain_sck_count", sckCount, 32'd24);
    doUpdate();
    checkOutput("chainB_csn_update", {31'd0, csn}, 32'd1);

    $display("[TB] abort mid transfer");
    sckCount = 0;
    sendHeader(16'h4064);
    for (int i = 0; i < 40; i++) begin
      shiftBit(1'(i % 3 == 0), 1'b0);
    end
    checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
    checkOutput("abort_sck_count", sckCount, 32'd40);
    doUpdate();
    checkOutput("abort_csn", {31'd0, csn}, 32'd1);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_sck_en", {31'd0, sckEn}, 32'd0);
    sckCount = 0;
    sendHeader(16'h4008);
    xferBits(8, 32'h0000_00A5, 32'h0000_0000, got);
    checkOutput("post_abort_sck_count", sckCount, 32'd8);
    checkOutput("post_abort_csn_done", {31'd0, csn}, 32'd1);
    doUpdate();

    $display("[TB] zero length frame");
    sckCount = 0;
    sendHeader(16'h4000);
    checkOutput("zero_busy", {31'd0, busy}, 32'd0);
    shiftBit(1'b1, 1'b0);
    shiftBit(1'b1, 1'b0);
    checkOutput("zero_sck_count", sckCount, 32'd0);
    checkOutput("zero_csn", {31'd0, csn}, 32'd1);
    doUpdate();

    $display("[TB] reset during transfer");
    sckCount = 0;
    sendHeader(16'h4010);
    for (int i = 0; i < 5; i++) begin
      shiftBit(1'b1, 1'b0);
    end
    checkOutput("rstmid_csn_before", {31'd0, csn}, 32'd0);
    rst = 1'b1;
    shiftBit(1'b1, 1'b0);
    checkOutput("rstmid_csn", {31'd0, csn}, 32'd1);
    checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstmid_sck_en", {31'd0, sckEn}, 32'd0);
    checkOutput("rstmid_tdo", {31'd0, tdo}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      shiftBit(1'b1, 1'b1);
    end
    checkOutput("rstmid_sck_count", sckCount, 32'd5);
    checkOutput("rstmid_csn_after", {31'd0, csn}, 32'd1);
    checkOutput("rstmid_busy_after", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_jtag_frame_ctrl.md
Name: spi_jtag_frame_ctrl

Overview:
Framing controller between the USER-chain JTAG primitive and the SPI flash pins, one stage downstream of the raw JTAG tap outputs.
- Replaces the free-running "CS low from CAPTURE to UPDATE" scheme with a header-described transfer.
- The host shifts a 16-bit header, then data. The block drives CS/SCK-enable/DQ0 for exactly the announced bit count and returns flash DQ1 on TDO, aligned.
- Lets the host chain commands with CS held low across DR scans.

Parameters:
LEN_W, 13, width of transfer length field (max 8191 SPI bits per frame)
RD_DLY, 1, extra register stages applied to sdo_dq1 before tdo (0..3)
MAGIC, 2'b01, required value of header bits [15:14]

Ports:
clk  in  1  JTAG-derived shift clock (DRCK/TCK); all logic on rising edge
rst  in  1  synchronous, active-high reset
sel  in  1  USER instruction active
capture  in  1  TAP in Capture-DR
shift  in  1  TAP in Shift-DR
update  in  1  TAP in Update-DR
tdi  in  1  serial data from tap
tdo  out  1  serial data to tap
sdo_dq1  in  1  flash serial output
sdi_dq0  out  1  flash serial input
csn  out  1  flash chip select, active low
sck_en  out  1  enables SCK gating (SCK = clk & sck_en, gated outside)
busy  out  1  high while state is XFER

Behaviour:
- Reset: state IDLE; csn=1, sck_en=0, sdi_dq0=0, tdo=0, busy=0, keep flag=0, counters=0. Takes priority over all inputs, including mid-transfer (csn rises next edge).
- act = sel & shift. Only act cycles consume a tdi bit.
- States:
  - IDLE: capture&sel -> HDR, hdr_cnt=0.
  - HDR: shift header LSB-first; on the 16th act bit, evaluate:
    - bits[15:14]!=MAGIC -> IGNORE.
    - len=bits[LEN_W-1:0]; len==0 -> DONE.
    - else -> XFER, bit_cnt=len.
    - keep = bit13.
  - XFER: each act cycle: sdi_dq0<=tdi, sck_en<=1, csn<=0, bit_cnt-=1; when bit_cnt reaches 0 -> DONE. Non-act cycles: sck_en<=0, csn held.
  - DONE: sck_en=0; csn=0 if keep else 1.
  - IGNORE: csn and sck_en unchanged from before frame; tdo passthrough.
- Any state, update&sel -> IDLE; csn<=~keep (keep=0 -> CS high, else stays low for next frame).
- update&sel asserted while in XFER = abort: csn<=1 regardless of keep, keep<=0.
- capture&sel in any state restarts HDR; csn retains its value, so chained frames stay selected.
- Output latency: sdi_dq0/sck_en/csn are registered, so the SPI side lags tdi by exactly one clk.
- tdo:
  - In XFER/DONE: sdo_dq1 delayed 1+RD_DLY clocks, so bit k returned on DR bit 16+k+1+RD_DLY (LSB-first count).
  - In IDLE/HDR/IGNORE: tdo=tdi registered one clk (bypass echo).
- The host pads the DR scan with ≥1+RD_DLY trailing bits; extra act bits after DONE are ignored (no SCK).
- bit_cnt never wraps: decrement only while >0.
- busy = (state==XFER).

Decomposition:
- Shared package spi_jtag_pkg:
  - state enum {IDLE,HDR,XFER,DONE,IGNORE}
  - HDR_W=16, MAGIC default, header field offsets (LEN lsb 0, KEEP 13, MAGIC 15:14)
- One sub-module: spi_jtag_rd_align (parameterised RD_DLY shift register for sdo->tdo, reset to 0).

Test Plan:
- Reset: hold rst 3 clks with random inputs -> csn=1, sck_en=0, tdo=0, busy=0 after the first rst edge.
- Read ID: header 0x4020 (len=32, keep=0), then 0x9F + 24 dummy bits, flash model returns EF 40 18 -> sck_en high exactly 32 clks; csn low 32 clks; tdo carries EF4018 at bits 16+8+1+RD_DLY onward; csn=1 after update.
- Bad magic: header 0xC008 followed by 8 bits -> csn stays 1, sck_en never asserts, tdo echoes tdi delayed 1 clk.
- Chaining: frame A 0x6008 (keep=1, len=8, 0x06), update, frame B 0x4010 (len=16) -> csn stays 0 across update and capture; total 24 SCK pulses; csn=1 after B's update.
- Abort: len=100 header 0x4064, update&sel after 40 data bits -> csn=1 next clk, busy=0, sck_en=0; the following frame starts in HDR normally.
- Zero length plus mid-transfer reset: header 0x4000 -> no SCK, csn=1. Then len=16 with rst at data bit 5 -> csn=1 and state IDLE next clk; remaining shift bits produce no SCK.
